// File: rtl/apb4_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb4_master_ctrl
// Purpose  : APB4 requester. Turns a valid/ready command stream into APB4
//            SETUP/ACCESS transfers and returns a valid/ready response stream.
//            It handles PREADY wait states, captures PSLVERR and aborts an
//            ACCESS phase that stalls for TIMEOUT cycles.
// Ports    : PCLK/PRESETn            - clock, asynchronous active-low reset
//            cmd_*                   - command stream (valid/ready)
//            rsp_*                   - response stream (valid/ready)
//            PSEL..PPROT             - APB4 requester outputs (registered)
//            PRDATA/PREADY/PSLVERR   - APB4 completer inputs
// Options  : APB4_MASTER_B2B_EN - when defined, the response path becomes a
//            2-entry FIFO, the RESP state is removed and a new command may be
//            launched in the same cycle an ACCESS completes.
// Revision : 1.0 - initial release
// ============================================================================
module apb4_master_ctrl #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [DATA_W-1:0]     PWDATA,
  output logic [DATA_W/8-1:0]   PSTRB,
  output logic [2:0]            PPROT,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int unsigned STRB_W = DATA_W / 8;
  // Counter value at which a still-stalled ACCESS is aborted.
  localparam logic [CNT_W-1:0] c_TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e              state_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [STRB_W-1:0]   pstrb_q;
  logic [2:0]          pprot_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic                rsp_to_q;

  logic                w_to_hit;
  logic                w_done;
  logic [DATA_W-1:0]   w_done_rdata;
  logic                w_done_err;
  logic                w_done_to;
  logic                w_accept;

  // PREADY has priority: an abort only happens when the completer is still
  // stalling in the last allowed cycle.
  assign w_to_hit     = (TIMEOUT != 0) && !PREADY && (cnt_q == c_TO_LAST);
  assign w_done       = (state_q == S_ACCESS) && (PREADY || w_to_hit);
  assign w_done_rdata = (PREADY && !pwrite_q) ? PRDATA : '0;
  assign w_done_err   = PREADY ? PSLVERR : 1'b1;
  assign w_done_to    = !PREADY;
  assign w_accept     = cmd_valid && cmd_ready;

`ifdef APB4_MASTER_B2B_EN
  // Response FIFO: the head lives in rsp_*_q (so outputs stay registered),
  // the second entry in tail_*_q.
  logic [1:0]          fifo_cnt_q;
  logic [DATA_W-1:0]   tail_rdata_q;
  logic                tail_err_q;
  logic                tail_to_q;
  logic                w_push;
  logic                w_pop;
  logic [1:0]          w_occ_next;

  assign w_push     = w_done;
  assign w_pop      = rsp_valid_q && rsp_ready;
  assign w_occ_next = fifo_cnt_q + {1'b0, w_push} - {1'b0, w_pop};
  // Accept only if the FIFO holds at most one entry after this cycle; the new
  // transfer needs at least two cycles to complete and nothing else can push
  // meanwhile, so its completion always finds a free slot.
  assign cmd_ready  = ((state_q == S_IDLE) || w_done) && (w_occ_next <= 2'd1);
`else
  assign cmd_ready  = (state_q == S_IDLE);
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
`ifdef APB4_MASTER_B2B_EN
      fifo_cnt_q   <= '0;
      tail_rdata_q <= '0;
      tail_err_q   <= 1'b0;
      tail_to_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_done) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
`ifdef APB4_MASTER_B2B_EN
            state_q   <= S_IDLE;
`else
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= w_done_rdata;
            rsp_err_q   <= w_done_err;
            rsp_to_q    <= w_done_to;
            state_q     <= S_RESP;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifndef APB4_MASTER_B2B_EN
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase

      // A launch overrides the return to IDLE of a completing transfer.
      if (w_accept) begin
        paddr_q   <= cmd_addr;
        pwrite_q  <= cmd_write;
        pwdata_q  <= cmd_wdata;
        pprot_q   <= cmd_prot;
        pstrb_q   <= cmd_write ? cmd_strb : '0;  // reads must drive PSTRB low
        psel_q    <= 1'b1;
        penable_q <= 1'b0;
        cnt_q     <= '0;
        state_q   <= S_SETUP;
      end

`ifdef APB4_MASTER_B2B_EN
      if (w_push && !w_pop) begin
        if (fifo_cnt_q == 2'd0) begin
          rsp_rdata_q <= w_done_rdata;
          rsp_err_q   <= w_done_err;
          rsp_to_q    <= w_done_to;
        end else begin
          tail_rdata_q <= w_done_rdata;
          tail_err_q   <= w_done_err;
          tail_to_q    <= w_done_to;
        end
      end else if (!w_push && w_pop) begin
        if (fifo_cnt_q == 2'd2) begin
          rsp_rdata_q <= tail_rdata_q;
          rsp_err_q   <= tail_err_q;
          rsp_to_q    <= tail_to_q;
        end
      end else if (w_push && w_pop) begin
        if (fifo_cnt_q == 2'd1) begin
          rsp_rdata_q <= w_done_rdata;
          rsp_err_q   <= w_done_err;
          rsp_to_q    <= w_done_to;
        end else begin
          rsp_rdata_q  <= tail_rdata_q;
          rsp_err_q    <= tail_err_q;
          rsp_to_q     <= tail_to_q;
          tail_rdata_q <= w_done_rdata;
          tail_err_q   <= w_done_err;
          tail_to_q    <= w_done_to;
        end
      end
      fifo_cnt_q  <= w_occ_next;
      rsp_valid_q <= (w_occ_next != 2'd0);
`endif
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign PPROT       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_to_q;

endmodule
`default_nettype wire

// File: tb/tb_apb4_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb4_master_ctrl
// Purpose  : Self-checking bench for apb4_master_ctrl. Stimulus pushes the
//            expected response into a queue; a monitor pops and compares on
//            every response handshake and checks response latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb4_master_ctrl;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic [2:0]    cmd_prot = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [2:0]    PPROT;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  apb4_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16), .CNT_W(5)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- completer model ----------------
  int          ws_cfg = 0;
  int          ws_cnt = 0;
  logic        err_wait = 1'b0;
  logic        err_ready = 1'b0;
  logic        addr_data = 1'b0;
  logic [31:0] rdata_cfg = '0;

  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      PREADY  = (ws_cnt >= ws_cfg);
      PSLVERR = PREADY ? err_ready : err_wait;
      PRDATA  = !PREADY ? 32'hDEAD_BEEF : (addr_data ? (32'hCAFE_0000 | {20'h0, PADDR}) : rdata_cfg);
      ws_cnt++;
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = '0;
      ws_cnt  = 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          cyc;   // cycle rsp_valid must first appear; 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_valid = 1'b0;

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid && exp_q.size() != 0 && exp_q[0].cyc != 0)
        chk("rsp_latency", cyc, exp_q[0].cyc);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rsp_unexpected: got response rdata 0x%0h, expected none", rsp_rdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_err", rsp_err, mon_e.err);
          chk("rsp_timeout", rsp_timeout, mon_e.to);
        end
      end
      prev_valid = rsp_valid && !rsp_ready;
    end
  end

  // ---------------- stimulus helpers (entered at a falling edge) ----------------
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [SW-1:0] strb, input logic [2:0] prot, input bit track,
                       input logic [31:0] e_rdata, input logic e_err, input logic e_to,
                       input int lat, output int acc);
    int   n;
    exp_t e;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
    cmd_valid = 1'b1;
    n = 0;
    #1;
    while (!cmd_ready && n < 200) begin
      @(negedge PCLK); #1; n++;
    end
    chk("cmd_accepted", cmd_ready, 1'b1);
    acc = cyc;
    if (track && cmd_ready) begin
      e.rdata = e_rdata; e.err = e_err; e.to = e_to;
      e.cyc = (lat > 0) ? cyc + lat : 0;
      exp_q.push_back(e);
    end
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    #1;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 300) begin
      @(negedge PCLK); #1; n++;
    end
    chk("idle_reached", {exp_q.size() == 0, cmd_ready}, 2'b11);
    @(negedge PCLK);
  endtask

`ifdef APB4_MASTER_B2B_EN
  localparam logic HOLD_RDY = 1'b1;  // one queued response still leaves room
`else
  localparam logic HOLD_RDY = 1'b0;
`endif

  int acc;
  int k;
  int accs[4];

  initial begin
    #3 PRESETn = 1'b0;
    @(negedge PCLK); @(negedge PCLK);
    // reset state
    chk("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PSTRB, PPROT}, '0);
    chk("reset_pwdata", PWDATA, '0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, '0);
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // 1: zero-wait write, APB phase shape and latency
    issue(1'b1, 12'h004, 32'h0000_FFF0, 4'hF, 3'b000, 1, 32'h0, 1'b0, 1'b0, 3, acc);
    chk("t1_setup", {PSEL, PENABLE, PWRITE, PSTRB}, {1'b1, 1'b0, 1'b1, 4'hF});
    chk("t1_paddr", PADDR, 12'h004);
    chk("t1_pwdata", PWDATA, 32'h0000_FFF0);
    @(negedge PCLK);
    chk("t1_access", {PSEL, PENABLE}, 2'b11);
    @(negedge PCLK);
    chk("t1_released", {PSEL, PENABLE}, 2'b00);
    chk("t1_paddr_hold", {PADDR, PWDATA}, {12'h004, 32'h0000_FFF0});
    wait_idle();

    // 2: read with 3 wait states; PSTRB forced low
    ws_cfg = 3; rdata_cfg = 32'h0000_F0FF;
    issue(1'b0, 12'h008, 32'h0, 4'hF, 3'b000, 1, 32'h0000_F0FF, 1'b0, 1'b0, 6, acc);
    chk("t2_pstrb_read", PSTRB, 4'h0);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      if (PSEL && PADDR == 12'h008) k++;
      @(negedge PCLK);
    end
    chk("t2_paddr_stable_cycles", k, 5);
    chk("t2_psel_drop", PSEL, 1'b0);
    wait_idle();

    // 3a: PSLVERR with PREADY
    ws_cfg = 0; err_ready = 1'b1;
    issue(1'b1, 12'h00C, 32'h1111_2222, 4'h5, 3'b001, 1, 32'h0, 1'b1, 1'b0, 3, acc);
    wait_idle();
    // 3b: PSLVERR only during wait states is ignored
    err_ready = 1'b0; err_wait = 1'b1; ws_cfg = 2; rdata_cfg = 32'h1234_5678;
    issue(1'b0, 12'h010, 32'h0, 4'h0, 3'b000, 1, 32'h1234_5678, 1'b0, 1'b0, 5, acc);
    wait_idle();
    err_wait = 1'b0;

    // 4: timeout after 16 stalled ACCESS cycles
    ws_cfg = 1000;
    issue(1'b0, 12'h020, 32'h0, 4'h0, 3'b010, 1, 32'h0, 1'b1, 1'b1, 18, acc);
    chk("t4_pprot", PPROT, 3'b010);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (!PENABLE) break;
      k++;
    end
    chk("t4_access_cycles", k, 16);
    chk("t4_psel_drop", PSEL, 1'b0);
    wait_idle();
    ws_cfg = 0;
    issue(1'b1, 12'h024, 32'hA5A5_A5A5, 4'h3, 3'b000, 1, 32'h0, 1'b0, 1'b0, 3, acc);
    chk("t4_next_pstrb", {PSTRB, PADDR}, {4'h3, 12'h024});
    wait_idle();

    // 5: response back-pressure for 10 cycles
    @(posedge PCLK); #2 rsp_ready = 1'b0;
    @(negedge PCLK);
    rdata_cfg = 32'h0BAD_F00D;
    issue(1'b0, 12'h030, 32'h0, 4'h0, 3'b000, 1, 32'h0BAD_F00D, 1'b0, 1'b0, 3, acc);
    k = 0;
    while (!rsp_valid && k < 10) begin @(negedge PCLK); k++; end
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t5_hold_ctrl", {rsp_valid, cmd_ready, PSEL, PENABLE}, {1'b1, HOLD_RDY, 2'b00});
      chk("t5_hold_data", {rsp_rdata, rsp_err, rsp_timeout}, {32'h0BAD_F00D, 2'b00});
      @(negedge PCLK);
    end
    @(posedge PCLK); #2 rsp_ready = 1'b1;
    @(negedge PCLK);
    wait_idle();

    // 5b: asynchronous reset in the middle of ACCESS
    ws_cfg = 1000;
    issue(1'b0, 12'h040, 32'h0, 4'h0, 3'b101, 0, 32'h0, 1'b0, 1'b0, 0, acc);
    @(negedge PCLK);
    chk("t5_in_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    chk("t5_async_apb", {PSEL, PENABLE, PWRITE, PADDR, PSTRB, PPROT}, '0);
    chk("t5_async_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, '0);
    chk("t5_async_idle", cmd_ready, 1'b1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    ws_cfg = 0;
    @(negedge PCLK);
    issue(1'b1, 12'h044, 32'h0000_0001, 4'h1, 3'b000, 1, 32'h0, 1'b0, 1'b0, 3, acc);
    wait_idle();

`ifdef APB4_MASTER_B2B_EN
    // 6: back-to-back reads, 2-cycle spacing, in-order responses
    addr_data = 1'b1;
    for (int i = 0; i < 4; i++)
      issue(1'b0, 12'h010 + 12'(4 * i), 32'h0, 4'h0, 3'b000, 1,
            32'hCAFE_0010 + 32'(4 * i), 1'b0, 1'b0, 0, accs[i]);
    for (int i = 0; i < 3; i++) chk("t6_spacing", accs[i+1] - accs[i], 2);
    wait_idle();
    @(posedge PCLK); #2 rsp_ready = 1'b0;
    @(negedge PCLK);
    issue(1'b0, 12'h020, 32'h0, 4'h0, 3'b000, 1, 32'hCAFE_0020, 1'b0, 1'b0, 0, acc);
    issue(1'b0, 12'h024, 32'h0, 4'h0, 3'b000, 1, 32'hCAFE_0024, 1'b0, 1'b0, 0, acc);
    repeat (6) @(negedge PCLK);
    #1 chk("t6_full", {cmd_ready, rsp_valid, PSEL}, 3'b010);
    @(posedge PCLK); #2 rsp_ready = 1'b1;
    @(negedge PCLK);
    wait_idle();
    addr_data = 1'b0;
`endif

    repeat (3) @(negedge PCLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
